sipo_frame_ctrl: RTL and testbench

Controller that sequences a serial-in/parallel-out shift path into framed words. It detects a frame start, counts WIDTH qualified serial bits into an internal shift register, and hands the assembled word to a consumer through a one-entry valid/ready holding register. It reports overrun and, optionally, parity errors. It sits between a bit-serial source (link or bit-bang front end) and a byte-wide consumer.

---
 rtl/sipo_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: frame start detect, WIDTH-bit shift,
// one-entry valid/ready holding register, sticky overrun. Optional macro PARITY_CHECK_EN adds an even-parity stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | outside a frame, bit_valid ignored, waiting for frame_start
// S_SHIFT  | collecting data bits into the shift register
// S_PARITY | data complete, waiting for the even-parity bit (macro only)

module sipo_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr_shift;
    logic             last_bit;
    logic             done;
    logic [WIDTH-1:0] done_word;
`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        if (MSB_FIRST != 0) sr_shift = {sr_q[WIDTH-2:0], bit_in};
        else                sr_shift = {bit_in, sr_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        done      = 1'b0;
        done_word = sr_shift;
`ifdef PARITY_CHECK_EN
        perr_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            S_SHIFT: begin
                // a restart outranks any coincident bit
                if (frame_start) begin
                    cnt_d = '0;
                    sr_d  = '0;
                end else if (bit_valid) begin
                    sr_d = sr_shift;
                    if (last_bit) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
                        done    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (frame_start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end else if (bit_valid) begin
                    state_d = S_IDLE;
                    if (((^sr_q) ^ bit_in) == 1'b0) begin
                        done      = 1'b1;
                        done_word = sr_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (valid_q && word_ready) valid_d = 1'b0;
        if (overrun_clr)           ovr_d   = 1'b0;

        // a set in the same cycle as a clear wins
        if (done) begin
            if (!valid_q || word_ready) begin
                word_d  = done_word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign bit_count  = cnt_q;
    assign overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: a vector table for the first frame, hand sequences for
// overrun / handshake / restart / reset corners, then random traffic against a queue-based model.

module tb_sipo_frame_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    logic reset, frame_start, bit_valid, bit_in, word_ready, overrun_clr;
    logic [W-1:0]  m_word, l_word;
    logic          m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_perr, l_perr;
    logic [CW-1:0] m_cnt, l_cnt;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_in(bit_in), .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
        .busy(m_busy), .bit_count(m_cnt), .overrun(m_ovr), .overrun_clr(overrun_clr),
        .parity_err(m_perr));

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_in(bit_in), .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
        .busy(l_busy), .bit_count(l_cnt), .overrun(l_ovr), .overrun_clr(overrun_clr),
        .parity_err(l_perr));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // reference model: frame bits in arrival order, held word for both bit orders
    bit           md_in_frame, md_in_par, md_hv, md_ovr, md_perr;
    bit           md_bits[$];
    logic [W-1:0] md_hw_msb, md_hw_lsb;

    function automatic void model_step(bit rst, bit fs, bit bv, bit bi, bit rdy, bit oclr);
        bit hv_old = md_hv;
        bit done   = 1'b0;
        bit par;
        if (rst) begin
            md_in_frame = 0; md_in_par = 0; md_hv = 0; md_ovr = 0; md_perr = 0;
            md_hw_msb = '0; md_hw_lsb = '0; md_bits.delete();
            return;
        end
        md_perr = 0;
        if (md_hv && rdy) md_hv = 0;
        if (oclr) md_ovr = 0;
        if (fs) begin
            md_in_frame = 1; md_in_par = 0; md_bits.delete();
        end else if (md_in_frame && bv) begin
            if (md_in_par) begin
                par = bi;
                foreach (md_bits[i]) par ^= md_bits[i];
                if (par == 0) done = 1; else md_perr = 1;
                md_in_frame = 0; md_in_par = 0;
            end else begin
                md_bits.push_back(bi);
                if (md_bits.size() == W) begin
                    if (PAR) md_in_par = 1;
                    else begin done = 1; md_in_frame = 0; end
                end
            end
        end
        if (done) begin
            if (!hv_old || rdy) begin
                md_hw_msb = '0; md_hw_lsb = '0;
                for (int i = 0; i < W; i++) begin
                    md_hw_msb[W-1-i] = md_bits[i];
                    md_hw_lsb[i]     = md_bits[i];
                end
                md_hv = 1;
            end else begin
                md_ovr = 1;
            end
        end
        if (!md_in_frame) md_bits.delete();
    endfunction

    function automatic int model_cnt();
        return (md_in_par || !md_in_frame) ? 0 : md_bits.size();
    endfunction

    task automatic check_all();
        chk("word_valid",   32'(m_valid), 32'(md_hv));
        chk("word_out_msb", 32'(m_word),  32'(md_hw_msb));
        chk("word_valid_l", 32'(l_valid), 32'(md_hv));
        chk("word_out_lsb", 32'(l_word),  32'(md_hw_lsb));
        chk("busy",         32'(m_busy),  32'(md_in_frame));
        chk("bit_count",    32'(m_cnt),   32'(model_cnt()));
        chk("overrun",      32'(m_ovr),   32'(md_ovr));
        chk("parity_err",   32'(m_perr),  32'(md_perr));
    endtask

    task automatic cyc(input bit rst, input bit fs, input bit bv, input bit bi,
                       input bit rdy, input bit oclr);
        reset = rst; frame_start = fs; bit_valid = bv; bit_in = bi;
        word_ready = rdy; overrun_clr = oclr;
        model_step(rst, fs, bv, bi, rdy, oclr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // data bits MSB of w first, optional idle gap before bit index gap_at, parity bit if enabled
    task automatic send_bits(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input int gap_at);
        for (int i = 0; i < W; i++) begin
            if (gap_at == i) cyc(L, L, L, H, rdy, L);
            cyc(L, L, H, w[W-1-i], (i == W-1 && !PAR) ? rdy_last : rdy, L);
        end
        if (PAR) cyc(L, L, H, ^w, rdy_last, L);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
        cyc(L, H, L, L, rdy, L);
        send_bits(w, rdy, rdy_last, -1);
    endtask

    typedef struct {
        bit rst, fs, bv, bi, rdy;
        bit ev, eb;
        logic [W-1:0] ew, ewl;
        int ec;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rst, bit fs, bit bv, bit bi, bit rdy,
                                bit ev, logic [W-1:0] ew, logic [W-1:0] ewl, bit eb, int ec);
        vec_t v;
        v.rst = rst; v.fs = fs; v.bv = bv; v.bi = bi; v.rdy = rdy;
        v.ev = ev; v.ew = ew; v.ewl = ewl; v.eb = eb; v.ec = ec;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] pat;
        reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        word_ready = 1'b0; overrun_clr = 1'b0;

        // first frame 1,0,1,0,1,0,1,0 with word_ready held high
        pat = 8'hAA;
        add(H, L, L, L, H, L, 8'h00, 8'h00, L, 0);
        add(H, L, L, L, H, L, 8'h00, 8'h00, L, 0);
        add(L, H, L, L, H, L, 8'h00, 8'h00, H, 0);
        for (int k = 0; k < W; k++) begin
            if (k == W-1 && !PAR) add(L, L, H, pat[W-1-k], H, H, 8'hAA, 8'h55, L, 0);
            else add(L, L, H, pat[W-1-k], H, L, 8'h00, 8'h00, H, (k == W-1) ? 0 : k + 1);
        end
        if (PAR) add(L, L, H, L, H, H, 8'hAA, 8'h55, L, 0);
        add(L, L, L, L, H, L, 8'hAA, 8'h55, L, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; frame_start = tbl[i].fs; bit_valid = tbl[i].bv;
            bit_in = tbl[i].bi; word_ready = tbl[i].rdy; overrun_clr = 1'b0;
            model_step(tbl[i].rst, tbl[i].fs, tbl[i].bv, tbl[i].bi, tbl[i].rdy, L);
            @(posedge clk);
            #1;
            chk("tbl_valid",  32'(m_valid), 32'(tbl[i].ev));
            chk("tbl_word",   32'(m_word),  32'(tbl[i].ew));
            chk("tbl_word_l", 32'(l_word),  32'(tbl[i].ewl));
            chk("tbl_busy",   32'(m_busy),  32'(tbl[i].eb));
            chk("tbl_cnt",    32'(m_cnt),   32'(tbl[i].ec));
            chk("tbl_ovr",    32'(m_ovr),   32'(0));
        end

        // 1,1,0,0,1,1,0,0 -> CC msb-first, 33 lsb-first
        send_word(8'hCC, H, H);
        chk("cc_msb", 32'(m_word), 32'h0000_00CC);
        chk("cc_lsb", 32'(l_word), 32'h0000_0033);
        cyc(L, L, L, L, H, L);

        // stalled consumer: second word dropped, overrun sticky until cleared
        send_word(8'hAA, L, L);
        send_word(8'hCC, L, L);
        chk("ovr_keep_word", 32'(m_word), 32'h0000_00AA);
        chk("ovr_set", 32'(m_ovr), 32'(1));
        cyc(L, L, L, L, L, H);
        chk("ovr_clr", 32'(m_ovr), 32'(0));
        chk("ovr_valid_held", 32'(m_valid), 32'(1));
        cyc(L, L, L, L, H, L);
        chk("drain_valid", 32'(m_valid), 32'(0));

        // consume on the exact completion edge of the second frame
        send_word(8'hAA, L, L);
        send_word(8'hCC, L, H);
        chk("b2b_word", 32'(m_word), 32'h0000_00CC);
        chk("b2b_valid", 32'(m_valid), 32'(1));
        chk("b2b_ovr", 32'(m_ovr), 32'(0));
        cyc(L, L, L, L, H, L);

        // restart after 5 bits; a coincident bit_valid on the restart is ignored
        cyc(L, H, L, L, H, L);
        for (int i = 0; i < 5; i++) cyc(L, L, H, H, H, L);
        chk("partial_cnt", 32'(m_cnt), 32'(5));
        cyc(L, H, H, H, H, L);
        chk("restart_cnt", 32'(m_cnt), 32'(0));
        send_bits(8'h3C, H, H, 3);
        chk("restart_word", 32'(m_word), 32'h0000_003C);
        chk("restart_valid", 32'(m_valid), 32'(1));

        // reset mid-frame with a word still held
        cyc(L, H, L, L, L, L);
        for (int i = 0; i < 4; i++) cyc(L, L, H, H, L, L);
        cyc(H, L, L, L, L, L);
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_word",  32'(m_word),  32'(0));
        chk("rst_busy",  32'(m_busy),  32'(0));
        chk("rst_cnt",   32'(m_cnt),   32'(0));
        cyc(L, L, H, H, H, L);
        chk("idle_bit_ignored", 32'(m_busy), 32'(0));

`ifdef PARITY_CHECK_EN
        send_word(8'hAA, H, H);
        chk("par_ok_word", 32'(m_word), 32'h0000_00AA);
        cyc(L, L, L, L, H, L);
        cyc(L, H, L, L, H, L);
        send_bits_nopar: begin
            pat = 8'hAB;
            for (int i = 0; i < W; i++) cyc(L, L, H, pat[W-1-i], H, L);
        end
        cyc(L, L, H, L, H, L);
        chk("par_err_pulse", 32'(m_perr), 32'(1));
        chk("par_err_valid", 32'(m_valid), 32'(0));
        cyc(L, L, L, L, H, L);
        chk("par_err_clear", 32'(m_perr), 32'(0));
`endif

        // random traffic checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
